// File: rtl/pc_stack_if.sv
// pc_stack_if: control/data bundle between the PC control unit and the return-address stack
interface pc_stack_if #(parameter int DEPTH = 8, parameter int AW = 10);
   localparam int CW = $clog2(DEPTH) + 1;
   logic          push;
   logic          pop;
   logic [AW-1:0] pc_count;
   logic          clr_err;
   logic [AW-1:0] from_stack;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          underflow;
   modport master (
      output push, pop, pc_count, clr_err,
      input  from_stack, count, empty, full, overflow, underflow
   );
   modport slave (
      input  push, pop, pc_count, clr_err,
      output from_stack, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: hardware return-address stack feeding FROM_STACK to the PC mux.
// Define PC_STACK_WRAP_EN for circular push-on-full; otherwise pushes on full are dropped.
module pc_stack #(
   parameter int DEPTH = 8,
   parameter int AW    = 10
) (
   input logic         clk,
   input logic         rst_n,
   pc_stack_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
`ifdef PC_STACK_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   logic [AW-1:0] mem [DEPTH];
   logic [PW-1:0] ptr, ptr_n;
   logic [CW-1:0] count, count_n;
   logic          overflow, underflow, overflow_n, underflow_n;
   logic          empty, full, wr_new, replace, dec, we;
   logic [PW-1:0] waddr;
   logic [AW-1:0] wdata;
   always_comb begin
      empty       = count == '0;
      full        = count == CW'(DEPTH);
      wr_new      = bus.push && (!bus.pop || empty) && (!full || WRAP);
      replace     = bus.push && bus.pop && !empty;
      dec         = bus.pop && !bus.push && !empty;
      we          = wr_new || replace;
      waddr       = wr_new ? ptr + 1'b1 : ptr;
      wdata       = bus.pc_count + 1'b1;
      ptr_n       = wr_new ? ptr + 1'b1 : dec ? ptr - 1'b1 : ptr;
      count_n     = (wr_new && !full) ? count + 1'b1 : dec ? count - 1'b1 : count;
      // error set takes priority over a same-edge clear
      overflow_n  = (bus.push && !bus.pop && full) || (overflow && !bus.clr_err);
      underflow_n = (bus.pop && empty) || (underflow && !bus.clr_err);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         ptr       <= ptr_n;
         count     <= count_n;
         overflow  <= overflow_n;
         underflow <= underflow_n;
      end
   end
   always_ff @(posedge clk) begin
      if (we && rst_n) mem[waddr] <= wdata;
   end
   always_comb begin
      bus.from_stack = empty ? '0 : mem[ptr];
      bus.count      = count;
      bus.empty      = empty;
      bus.full       = full;
      bus.overflow   = overflow;
      bus.underflow  = underflow;
   end
endmodule
